// File: rtl/palette_pkg.sv
// Shared types, sizes and power-on colours for the double-buffered palette controller.
package palette_pkg;

  localparam int NUM_ENTRIES = 16;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);
  localparam int RGB_W       = 24;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COPY
  } state_t;

  // Entry 0 is the leftmost element; entries 10..15 are black.
  localparam logic [0:NUM_ENTRIES-1][RGB_W-1:0] DEFAULT_PALETTE = {
    24'hB0B0B0, 24'h0E490A, 24'h1A8512, 24'h21D113,
    24'h0F3D82, 24'h1C70EE, 24'h75A6F0, 24'h801313,
    24'hE60E0E, 24'hE66868, 24'h000000, 24'h000000,
    24'h000000, 24'h000000, 24'h000000, 24'h000000
  };

endpackage

// File: rtl/palette_if.sv
// Renderer lookup, VGA output and configuration/commit signals of the palette controller.
interface palette_if;
  import palette_pkg::*;

  logic pix_valid;
  idx_t colorIdx;
  logic frame_start;
  logic rgb_valid;
  rgb_t rgbVal;
  logic wr_valid;
  logic wr_ready;
  idx_t wr_idx;
  rgb_t wr_rgb;
  logic commit_req;
  logic commit_busy;
  logic commit_done;

  modport master (
    output pix_valid, colorIdx, frame_start,
    output wr_valid, wr_idx, wr_rgb, commit_req,
    input  rgb_valid, rgbVal, wr_ready, commit_busy, commit_done
  );

  modport slave (
    input  pix_valid, colorIdx, frame_start,
    input  wr_valid, wr_idx, wr_rgb, commit_req,
    output rgb_valid, rgbVal, wr_ready, commit_busy, commit_done
  );

endinterface

// File: rtl/palette_bank.sv
// NUM_ENTRIES x RGB_W register file: one synchronous write port, one combinational
// read port, synchronous reset to the default palette.
module palette_bank
  import palette_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  idx_t waddr,
  input  rgb_t wdata,
  input  idx_t raddr,
  output rgb_t rdata
);

  rgb_t mem_reg [NUM_ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem_reg[i] <= DEFAULT_PALETTE[i];
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // A read racing a write to the same entry sees the old value.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/palette_ctrl.sv
// Double-buffered palette: game logic fills the shadow bank, a commit copies it into the
// active bank during vertical blank, and renderer indices resolve through the active bank.
module palette_ctrl
  import palette_pkg::*;
(
  input  logic     Clk,
  input  logic     Reset,
  palette_if.slave bus
);

  state_t state_reg;
  idx_t   copy_idx_reg;
  logic   wr_ready_reg;
  logic   commit_busy_reg;
  logic   commit_done_reg;

  logic   pix_valid_s1_reg;
  idx_t   idx_s1_reg;
  logic   pix_valid_s2_reg;
  rgb_t   rgb_s2_reg;
  logic   rgb_valid_reg;
  rgb_t   rgb_val_reg;

  rgb_t   shadow_rdata;
  rgb_t   active_rdata;
  logic   shadow_we;
  logic   active_we;

  assign shadow_we = bus.wr_valid && wr_ready_reg;
  assign active_we = (state_reg == COPY);

  // The shadow read port belongs to the copy engine; lookups only ever see the active bank.
  palette_bank u_shadow (
    .clk   (Clk),
    .rst   (Reset),
    .we    (shadow_we),
    .waddr (bus.wr_idx),
    .wdata (bus.wr_rgb),
    .raddr (copy_idx_reg),
    .rdata (shadow_rdata)
  );

  palette_bank u_active (
    .clk   (Clk),
    .rst   (Reset),
    .we    (active_we),
    .waddr (copy_idx_reg),
    .wdata (shadow_rdata),
    .raddr (idx_s1_reg),
    .rdata (active_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= IDLE;
      copy_idx_reg    <= '0;
      wr_ready_reg    <= 1'b1;
      commit_busy_reg <= 1'b0;
      commit_done_reg <= 1'b0;
    end else begin
      commit_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.commit_req) begin
            state_reg       <= PENDING;
            wr_ready_reg    <= 1'b0;
            commit_busy_reg <= 1'b1;
          end
        end
        PENDING: begin
          if (bus.frame_start) begin
            state_reg    <= COPY;
            copy_idx_reg <= '0;
          end
        end
        COPY: begin
          copy_idx_reg <= copy_idx_reg + 1'b1;
          if (copy_idx_reg == idx_t'(NUM_ENTRIES - 1)) begin
            state_reg       <= IDLE;
            wr_ready_reg    <= 1'b1;
            commit_busy_reg <= 1'b0;
            commit_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Index capture, active-bank read, then the output register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_valid_s1_reg <= 1'b0;
      idx_s1_reg       <= '0;
      pix_valid_s2_reg <= 1'b0;
      rgb_s2_reg       <= '0;
      rgb_valid_reg    <= 1'b0;
      rgb_val_reg      <= '0;
    end else begin
      pix_valid_s1_reg <= bus.pix_valid;
      idx_s1_reg       <= bus.colorIdx;
      pix_valid_s2_reg <= pix_valid_s1_reg;
      rgb_s2_reg       <= active_rdata;
      rgb_valid_reg    <= pix_valid_s2_reg;
      rgb_val_reg      <= pix_valid_s2_reg ? rgb_s2_reg : '0;
    end
  end

  assign bus.wr_ready    = wr_ready_reg;
  assign bus.commit_busy = commit_busy_reg;
  assign bus.commit_done = commit_done_reg;
  assign bus.rgb_valid   = rgb_valid_reg;
  assign bus.rgbVal      = rgb_val_reg;

endmodule

// File: tb/tb_palette_ctrl.sv
// Bench for palette_ctrl: cycle-indexed reference model with a per-cycle scoreboard,
// a lookup vector table, directed commit/reset sequences and a random phase.
module tb_palette_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  palette_if bus ();

  palette_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference state: palette contents, commit phase and cycle-stamped expectations.
  logic [23:0] m_shadow [16];
  logic [23:0] m_active [16];
  int          m_mode    = 0;   // 0 idle, 1 waiting for vblank, 2 copying
  int          frame_cyc = 0;
  int          done_cyc  = -10;
  int          cyc       = 0;
  logic        last_v    = 1'b0;
  logic [3:0]  last_idx  = '0;
  logic        exp_v   [4];
  logic [23:0] exp_rgb [4];
  logic        chk_en    = 1'b0;

  typedef struct {
    logic        v;
    logic [3:0]  idx;
    logic        ev;
    logic [23:0] erg;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [23:0] ref_default(input int i);
    case (i)
      0: return 24'hB0B0B0;
      1: return 24'h0E490A;
      2: return 24'h1A8512;
      3: return 24'h21D113;
      4: return 24'h0F3D82;
      5: return 24'h1C70EE;
      6: return 24'h75A6F0;
      7: return 24'h801313;
      8: return 24'hE60E0E;
      9: return 24'hE66868;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // A lookup sampled at edge N resolves against the active bank as it stands before
  // edge N+1 and is visible after edge N+2. Entry k of a commit lands at edge F+1+k.
  task automatic model_step();
    int slot;
    int k;
    cyc++;
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        m_shadow[i] = ref_default(i);
        m_active[i] = ref_default(i);
      end
      m_mode   = 0;
      done_cyc = -10;
      last_v   = 1'b0;
      exp_v[cyc % 4]       = 1'b0;
      exp_rgb[cyc % 4]     = '0;
      exp_v[(cyc + 1) % 4]   = 1'b0;
      exp_rgb[(cyc + 1) % 4] = '0;
      chk_en   = 1'b1;
    end else begin
      slot = (cyc + 1) % 4;
      exp_v[slot]   = last_v;
      exp_rgb[slot] = last_v ? m_active[last_idx] : 24'h0;
      last_v   = bus.pix_valid;
      last_idx = bus.colorIdx;
      if (m_mode == 0) begin
        if (bus.wr_valid) m_shadow[bus.wr_idx] = bus.wr_rgb;
        if (bus.commit_req) m_mode = 1;
      end else if (m_mode == 1) begin
        if (bus.frame_start) begin
          m_mode    = 2;
          frame_cyc = cyc;
        end
      end else begin
        k = cyc - frame_cyc - 1;
        m_active[k] = m_shadow[k];
        if (k == 15) begin
          m_mode   = 0;
          done_cyc = cyc;
        end
      end
    end
  endtask

  task automatic scoreboard_step();
    int s;
    if (chk_en) begin
      s = cyc % 4;
      check("sb_rgb_valid", 32'(bus.rgb_valid), 32'(exp_v[s]));
      check("sb_rgbVal", 32'(bus.rgbVal), 32'(exp_rgb[s]));
      check("sb_wr_ready", 32'(bus.wr_ready), 32'(m_mode == 0));
      check("sb_commit_busy", 32'(bus.commit_busy), 32'(m_mode != 0));
      check("sb_commit_done", 32'(bus.commit_done), 32'(cyc == done_cyc));
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  initial forever begin
    @(negedge Clk);
    scoreboard_step();
  end

  task automatic idle_inputs();
    bus.pix_valid   = 1'b0;
    bus.colorIdx    = '0;
    bus.frame_start = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_idx      = '0;
    bus.wr_rgb      = '0;
    bus.commit_req  = 1'b0;
  endtask

  task automatic lookup_hold(input logic [3:0] idx);
    bus.pix_valid = 1'b1;
    bus.colorIdx  = idx;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    int n;
    int seen_new;
    int bad_order;
    int got_done;

    Reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge Clk);
    check("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("reset_rgb_valid", 32'(bus.rgb_valid), 32'd0);
    Reset = 1'b0;

    // Default palette lookups streamed back to back, then idle slots.
    tbl[0] = '{1'b1, 4'd0,  1'b1, 24'hB0B0B0};
    tbl[1] = '{1'b1, 4'd1,  1'b1, 24'h0E490A};
    tbl[2] = '{1'b1, 4'd8,  1'b1, 24'hE60E0E};
    tbl[3] = '{1'b1, 4'd15, 1'b1, 24'h000000};
    tbl[4] = '{1'b0, 4'd7,  1'b0, 24'h000000};
    tbl[5] = '{1'b0, 4'd2,  1'b0, 24'h000000};
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      if (i >= 3) begin
        check($sformatf("tbl%0d_valid", i - 3), 32'(bus.rgb_valid), 32'(tbl[i-3].ev));
        check($sformatf("tbl%0d_rgb", i - 3), 32'(bus.rgbVal), 32'(tbl[i-3].erg));
      end
      if (i < 6) begin
        bus.pix_valid = tbl[i].v;
        bus.colorIdx  = tbl[i].idx;
      end else begin
        bus.pix_valid = 1'b0;
      end
    end

    // Commit waits indefinitely for vertical blank.
    lookup_hold(4'd1);
    bus.wr_valid = 1'b1; bus.wr_idx = 4'd1; bus.wr_rgb = 24'h123456; bus.commit_req = 1'b1;
    @(negedge Clk);
    bus.wr_valid = 1'b0; bus.commit_req = 1'b0;
    for (int c = 0; c < 100; c++) begin
      check("pending_busy", 32'(bus.commit_busy), 32'd1);
      check("pending_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("pending_idx1_old", 32'(bus.rgbVal), 32'h0E490A);
      @(negedge Clk);
    end
    bus.frame_start = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      bus.frame_start = 1'b0;
      n++;
    end while (!bus.commit_done && n < 40);
    check("done_cycles_after_frame_start", 32'(n), 32'd17);
    check("done_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("done_busy_low", 32'(bus.commit_busy), 32'd0);
    check("idx1_new", 32'(bus.rgbVal), 32'h123456);

    // Write + commit in one cycle, a redundant commit in PENDING, idx 5 watched across the copy.
    bus.pix_valid = 1'b1; bus.colorIdx = 4'd5;
    @(negedge Clk);
    bus.wr_valid = 1'b1; bus.wr_idx = 4'd5; bus.wr_rgb = 24'h55AA55;
    @(negedge Clk);
    bus.wr_idx = 4'd3; bus.wr_rgb = 24'hABCDEF; bus.commit_req = 1'b1;
    @(negedge Clk);
    bus.wr_valid = 1'b0;
    @(negedge Clk);
    bus.commit_req = 1'b0;
    repeat (2) @(negedge Clk);
    bus.frame_start = 1'b1;
    seen_new = 0; bad_order = 0; got_done = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge Clk);
      bus.frame_start = 1'b0;
      check("copy_no_bubble", 32'(bus.rgb_valid), 32'd1);
      if (bus.rgbVal == 24'h55AA55) seen_new = 1;
      else if (bus.rgbVal != 24'h1C70EE || seen_new != 0) bad_order++;
      if (bus.commit_done) got_done++;
    end
    check("idx5_old_then_new", 32'(bad_order), 32'd0);
    check("idx5_switched", 32'(seen_new), 32'd1);
    check("single_commit_done", 32'(got_done), 32'd1);
    got_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (bus.commit_done) got_done++;
    end
    check("no_second_copy", 32'(got_done), 32'd0);
    bus.colorIdx = 4'd3;
    repeat (3) @(negedge Clk);
    check("idx3_committed", 32'(bus.rgbVal), 32'hABCDEF);

    // Reset in the middle of a copy.
    bus.wr_valid = 1'b1; bus.wr_idx = 4'd2; bus.wr_rgb = 24'h00FF00; bus.commit_req = 1'b1;
    @(negedge Clk);
    bus.wr_valid = 1'b0; bus.commit_req = 1'b0;
    @(negedge Clk);
    bus.frame_start = 1'b1;
    repeat (7) begin
      @(negedge Clk);
      bus.frame_start = 1'b0;
    end
    check("mid_copy_busy", 32'(bus.commit_busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("post_reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("post_reset_busy", 32'(bus.commit_busy), 32'd0);
    got_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (bus.commit_done) got_done++;
    end
    check("abandoned_copy_no_done", 32'(got_done), 32'd0);
    lookup_hold(4'd2);
    check("idx2_default", 32'(bus.rgbVal), 32'h1A8512);
    lookup_hold(4'd1);
    check("idx1_default", 32'(bus.rgbVal), 32'h0E490A);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      Reset           = ($urandom_range(0, 399) == 0);
      bus.pix_valid   = ($urandom_range(0, 3) != 0);
      bus.colorIdx    = 4'($urandom);
      bus.wr_valid    = 1'($urandom);
      bus.wr_idx      = 4'($urandom);
      bus.wr_rgb      = 24'($urandom);
      bus.commit_req  = ($urandom_range(0, 15) == 0);
      bus.frame_start = ($urandom_range(0, 29) == 0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    idle_inputs();
    repeat (5) @(negedge Clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
